// File: rtl/ip_pkg.sv
// ip_pkg: shared IPv4 receive types, header field offsets and one's-complement helper
package ip_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, PAYLOAD, DROP} ip_state_e;
  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IPV4_MIN_IHL = 4'd5;
  localparam logic [7:0] PROTO_UDP = 8'h11;
  localparam logic [7:0] PROTO_TCP = 8'h06;
  localparam int VER_MSB = 159;
  localparam int IHL_MSB = 155;
  localparam int TLEN_MSB = 143;
  localparam int PROTO_MSB = 87;
  localparam int SRC_MSB = 63;
  localparam int DST_MSB = 31;
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/ip_cksum_acc.sv
// ip_cksum_acc: folded one's-complement accumulator over 16-bit header words
//   clk, rst (async active-low), clr (sync clear), word_valid/word (addend), sum (running folded sum)
module ip_cksum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] sum
);
  logic [15:0] sum_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sum_q <= '0;
    else if (clr) sum_q <= '0;
    else if (word_valid) sum_q <= ones_add(sum_q, word);
  assign sum = sum_q;
endmodule

// File: rtl/internet_protocol_rx.sv
// internet_protocol_rx: IPv4 header parse/validate, option skip and payload forwarding
//   clk, rst (async active-low); axiiv/axiid: input beats (N bits, MSB-first per byte)
//   axiov/axiod/axi_last: payload beats; hdr_valid/hdr_err: verdict pulses
//   src_ip_out, dst_ip_out, protocol_out, payload_length_out: captured header fields
module internet_protocol_rx
  import ip_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         axi_last,
  output logic         hdr_valid,
  output logic         hdr_err,
  output logic [31:0]  src_ip_out,
  output logic [31:0]  dst_ip_out,
  output logic [7:0]   protocol_out,
  output logic [15:0]  payload_length_out
);
  localparam int HDR_BEATS = 160 / N;
  localparam int BYTE_BEATS = 8 / N;
  localparam int WB_BITS = $clog2(16 / N);
  ip_state_e state_q, state_d;
  logic [159:0] hdr_q, hdr_n;
  logic [15-N:0] word_q;
  logic [15:0] word_n, cnt_q, cnt_d, cnt_n, rem_q, rem_d, sum, sum_n, tlen, ihl_bytes, plen;
  logic [3:0] ihl;
  logic armed_q, start, hdr_beat, opt_beat, word_valid, hdr_end, opt_end, ok, byte_done;
  logic fwd, last, acc_ok, rej;
  logic axiov_q, last_q, hv_q, he_q;
  logic [N-1:0] axiod_q;
  logic [31:0] src_q, dst_q;
  logic [7:0] proto_q;
  logic [15:0] plen_q;
  ip_cksum_acc u_acc (
    .clk(clk), .rst(rst), .clr(state_q == IDLE), .word_valid(word_valid), .word(word_n), .sum(sum)
  );
  // after reset the block only starts on a fresh rising edge of axiiv
  assign start = state_q == IDLE && axiiv && armed_q;
  assign hdr_beat = start || (state_q == HEADER && axiiv);
  assign opt_beat = state_q == OPTIONS && axiiv;
  assign cnt_n = start ? 16'd1 : cnt_q + 16'd1;
  assign hdr_n = hdr_beat ? {hdr_q[159-N:0], axiid} : hdr_q;
  assign word_n = {word_q, axiid};
  assign word_valid = (hdr_beat || opt_beat) && cnt_n[WB_BITS-1:0] == '0;
  // the last word is folded in here so the verdict can register with the last beat
  assign sum_n = ones_add(sum, word_n);
  assign ihl = hdr_n[IHL_MSB -: 4];
  assign tlen = hdr_n[TLEN_MSB -: 16];
  assign ihl_bytes = {10'd0, ihl, 2'b00};
  assign hdr_end = state_q == HEADER && axiiv && cnt_n == 16'(HDR_BEATS);
  assign opt_end = opt_beat && cnt_n == 16'(ihl) * 16'(32 / N);
  assign ok = hdr_n[VER_MSB -: 4] == IPV4_VERSION && ihl >= IPV4_MIN_IHL && tlen >= ihl_bytes && sum_n == 16'hFFFF;
  assign plen = ok ? tlen - ihl_bytes : '0;
  assign byte_done = cnt_q == 16'(BYTE_BEATS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    fwd = 1'b0;
    last = 1'b0;
    acc_ok = 1'b0;
    rej = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = HEADER;
        cnt_d = cnt_n;
      end
      HEADER, OPTIONS: begin
        cnt_d = cnt_n;
        if (hdr_end && ihl > IPV4_MIN_IHL) state_d = OPTIONS;
        else if (hdr_end || opt_end) begin
          acc_ok = ok;
          rej = !ok;
          state_d = ok && plen != '0 ? PAYLOAD : DROP;
          cnt_d = '0;
          rem_d = plen;
        end
      end
      PAYLOAD: begin
        fwd = 1'b1;
        last = byte_done && rem_q == 16'd1;
        cnt_d = byte_done ? '0 : cnt_q + 16'd1;
        rem_d = rem_q - 16'(byte_done);
        state_d = last ? DROP : PAYLOAD;
      end
      default: ;
    endcase
    if (!axiiv) begin
      state_d = IDLE;
      cnt_d = '0;
      rem_d = '0;
      fwd = 1'b0;
      last = 1'b0;
      acc_ok = 1'b0;
      rej = state_q inside {HEADER, OPTIONS, PAYLOAD};
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      hdr_q <= '0;
      word_q <= '0;
      armed_q <= 1'b0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      last_q <= 1'b0;
      hv_q <= 1'b0;
      he_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      proto_q <= '0;
      plen_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      hdr_q <= hdr_n;
      word_q <= word_n[15-N:0];
      armed_q <= armed_q | ~axiiv;
      axiov_q <= fwd;
      axiod_q <= fwd ? axiid : '0;
      last_q <= last;
      hv_q <= acc_ok;
      he_q <= rej;
      if (acc_ok) begin
        src_q <= hdr_n[SRC_MSB -: 32];
        dst_q <= hdr_n[DST_MSB -: 32];
        proto_q <= hdr_n[PROTO_MSB -: 8];
        plen_q <= plen;
      end
    end
  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign axi_last = last_q;
  assign hdr_valid = hv_q;
  assign hdr_err = he_q;
  assign src_ip_out = src_q;
  assign dst_ip_out = dst_q;
  assign protocol_out = proto_q;
  assign payload_length_out = plen_q;
endmodule

// File: tb/tb_internet_protocol_rx.sv
// tb_internet_protocol_rx: table-driven scoreboard bench running every packet case for N = 1, 2, 4, 8
module tb_internet_protocol_rx;
  typedef struct {
    string name;
    logic [191:0] hw;
    int nw, npay, npad, fwd;
    bit ok, err, last;
    logic [15:0] plen;
  } vec_t;
  localparam logic [191:0] H_OK    = {160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, 32'h0};
  localparam logic [191:0] H_BADCK = {160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7, 32'h0};
  localparam logic [191:0] H_IHL6  = 192'h4600_0073_0000_4000_4011_B761_C0A8_0001_C0A8_00C7_0000_0000;
  localparam logic [191:0] H_V6    = {160'h6500_0073_0000_4000_4011_9861_C0A8_0001_C0A8_00C7, 32'h0};
  localparam logic [191:0] H_ZERO  = {160'h4500_0014_0000_4000_4011_B8C0_C0A8_0001_C0A8_00C7, 32'h0};
  localparam logic [191:0] H_SHORT = {160'h4500_0010_0000_4000_4011_B8C4_C0A8_0001_C0A8_00C7, 32'h0};
  localparam int NV = 7;
  logic clk = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  vec_t tv[NV];
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input string name, input logic [191:0] hw, input int nw, input int npay,
                              input int npad, input bit ok, input bit err, input int fwd, input bit last,
                              input logic [15:0] plen);
    vec_t v;
    v.name = name; v.hw = hw; v.nw = nw; v.npay = npay; v.npad = npad;
    v.ok = ok; v.err = err; v.fwd = fwd; v.last = last; v.plen = plen;
    return v;
  endfunction
  initial begin
    tv[0] = mk("valid", H_OK,    10, 95, 4, 1, 0, 95, 1, 16'd95);
    tv[1] = mk("badck", H_BADCK, 10, 95, 4, 0, 1, 0,  0, 16'd0);
    tv[2] = mk("ihl6",  H_IHL6,  12, 91, 4, 1, 0, 91, 1, 16'd91);
    tv[3] = mk("ver6",  H_V6,    10, 95, 4, 0, 1, 0,  0, 16'd0);
    tv[4] = mk("trunc", H_OK,    10, 40, 0, 1, 1, 40, 0, 16'd95);
    tv[5] = mk("zero",  H_ZERO,  10, 0,  6, 1, 0, 0,  0, 16'd0);
    tv[6] = mk("short", H_SHORT, 10, 10, 0, 0, 1, 0,  0, 16'd0);
  end
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int N = 1 << g;
    logic rst_n, axiiv, axiov, axi_last, hdr_valid, hdr_err;
    logic [N-1:0] axiid, axiod;
    logic [31:0] src_ip_out, dst_ip_out, mdl_src, mdl_dst;
    logic [7:0] protocol_out, mdl_proto;
    logic [15:0] payload_length_out, mdl_plen;
    logic [7:0] exp_d[$];
    bit exp_l[$];
    int hv_cnt = 0;
    int he_cnt = 0;
    internet_protocol_rx #(.N(N)) dut (
      .clk(clk), .rst(rst_n), .axiiv(axiiv), .axiid(axiid), .axiov(axiov), .axiod(axiod),
      .axi_last(axi_last), .hdr_valid(hdr_valid), .hdr_err(hdr_err), .src_ip_out(src_ip_out),
      .dst_ip_out(dst_ip_out), .protocol_out(protocol_out), .payload_length_out(payload_length_out)
    );
    function automatic string nm(input string s);
      return $sformatf("N%0d_%s", N, s);
    endfunction
    always @(posedge clk) begin
      #1;
      if (hdr_valid) hv_cnt++;
      if (hdr_err) he_cnt++;
      if (axiov) begin
        check(nm("axiov_expected"), 32'(exp_d.size() > 0), 1);
        if (exp_d.size() > 0) begin
          check(nm("axiod"), 32'(axiod), 32'(exp_d.pop_front()));
          check(nm("axi_last"), 32'(axi_last), 32'(exp_l.pop_front()));
        end
      end else check(nm("axi_last_idle"), 32'(axi_last), 0);
    end
    task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 8 / N; k++) begin
        @(negedge clk);
        axiiv = 1'b1;
        axiid = b[7-k*N -: N];
      end
    endtask
    task automatic push_byte(input logic [7:0] b, input bit last);
      for (int k = 0; k < 8 / N; k++) begin
        exp_d.push_back(8'(b[7-k*N -: N]));
        exp_l.push_back(last && k == 8 / N - 1);
      end
    endtask
    task automatic idle(input int n);
      @(negedge clk);
      axiiv = 1'b0;
      axiid = '0;
      repeat (n) @(negedge clk);
    endtask
    task automatic check_fields(input string tag);
      check(nm({tag, "_src"}), src_ip_out, mdl_src);
      check(nm({tag, "_dst"}), dst_ip_out, mdl_dst);
      check(nm({tag, "_proto"}), 32'(protocol_out), 32'(mdl_proto));
      check(nm({tag, "_plen"}), 32'(payload_length_out), 32'(mdl_plen));
    endtask
    task automatic check_reset(input string tag);
      #1;
      check(nm({tag, "_axiov"}), 32'(axiov), 0);
      check(nm({tag, "_axiod"}), 32'(axiod), 0);
      check(nm({tag, "_hdr_valid"}), 32'(hdr_valid), 0);
      check(nm({tag, "_hdr_err"}), 32'(hdr_err), 0);
      mdl_src = '0; mdl_dst = '0; mdl_proto = '0; mdl_plen = '0;
      check_fields(tag);
    endtask
    task automatic send_pkt(input vec_t v);
      int hv0, he0;
      logic [7:0] b;
      hv0 = hv_cnt;
      he0 = he_cnt;
      for (int i = 0; i < 2 * v.nw; i++) send_byte(v.hw[191-8*i -: 8]);
      for (int i = 0; i < v.npay + v.npad; i++) begin
        b = i < v.npay ? 8'(i * 37 + 5 + N) : 8'hEE;
        if (i < v.fwd) push_byte(b, v.last && i == v.fwd - 1);
        send_byte(b);
      end
      idle(4);
      if (v.ok) begin
        mdl_src = 32'hC0A8_0001;
        mdl_dst = 32'hC0A8_00C7;
        mdl_proto = 8'h11;
        mdl_plen = v.plen;
      end
      check(nm({v.name, "_hdr_valid_pulses"}), hv_cnt - hv0, 32'(v.ok));
      check(nm({v.name, "_hdr_err_pulses"}), he_cnt - he0, 32'(v.err));
      check(nm({v.name, "_beats_missing"}), exp_d.size(), 0);
      exp_d.delete();
      exp_l.delete();
      check_fields(v.name);
    endtask
    initial begin
      int hv0, he0;
      rst_n = 1'b0;
      axiiv = 1'b0;
      axiid = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NV; i++) send_pkt(tv[i]);
      hv0 = hv_cnt;
      he0 = he_cnt;
      for (int i = 0; i < 10; i++) send_byte(H_OK[191-8*i -: 8]);
      rst_n = 1'b0;
      check_reset("midrst");
      for (int i = 10; i < 12; i++) send_byte(H_OK[191-8*i -: 8]);
      rst_n = 1'b1;
      for (int i = 12; i < 20; i++) send_byte(H_OK[191-8*i -: 8]);
      for (int i = 0; i < 99; i++) send_byte(8'(i * 13 + 1));
      idle(4);
      check(nm("midrst_hdr_valid_pulses"), hv_cnt - hv0, 0);
      check(nm("midrst_hdr_err_pulses"), he_cnt - he0, 0);
      check_fields("midrst_after");
      send_pkt(tv[0]);
      done_cnt++;
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    for (int c = 0; c < 90000 && done_cnt < 4; c++) @(posedge clk);
    if (done_cnt < 4) check("timeout_done", 32'(done_cnt), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
